univ_shift_reg: RTL and testbench

Parametrised universal shift register: a DEPTH-stage chain, each stage LANE_W bits wide. It supports hold, shift-right, shift-left and parallel-load modes, with serial taps at both ends and a full parallel output. It replaces fixed 4-bit serial-in/serial-out shifters in serialiser, deserialiser and delay-line paths. A saturating shift counter flags when a complete word has been shifted since the last load.

---
 rtl/univ_shift_reg.sv | 101 ++++++++++
 tb/tb_univ_shift_reg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: DEPTH-stage, LANE_W-wide universal shift register
// with hold / shift-right / shift-left / parallel-load modes.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   en           clock enable; 0 holds all state including the counter
//   mode         00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin_r        serial input entering stage DEPTH-1 on shift right
//   sin_l        serial input entering stage 0 on shift left
//   pin          parallel load data, stage i = pin[i*LANE_W +: LANE_W]
//   pout         stage contents, same packing as pin
//   sout_r       stage 0 tap (right end)
//   sout_l       stage DEPTH-1 tap (left end)
//   shift_cnt    shifts since last load/reset, saturating at DEPTH
//   full         shift_cnt == DEPTH
module univ_shift_reg #(
    parameter int DEPTH  = 8,
    parameter int LANE_W = 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic [LANE_W-1:0]         sin_r,
    input  logic [LANE_W-1:0]         sin_l,
    input  logic [DEPTH*LANE_W-1:0]   pin,
    output logic [DEPTH*LANE_W-1:0]   pout,
    output logic [LANE_W-1:0]         sout_r,
    output logic [LANE_W-1:0]         sout_l,
    output logic [CNT_W-1:0]          shift_cnt,
    output logic                      full
);

    localparam int W = DEPTH * LANE_W;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [W-1:0]     stage_q;
    logic [W-1:0]     stage_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             shift_en;

    // Stage i lives at stage_q[i*LANE_W +: LANE_W]; stage 0 is the
    // least-significant lane, so a right shift is a downward lane move
    // with sin_r entering at the top, and a left shift the reverse.
    always_comb begin
        stage_d  = stage_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    stage_d = stage_q;
                end
                MODE_SHR: begin
                    stage_d  = {sin_r, stage_q[W-1:LANE_W]};
                    shift_en = 1'b1;
                end
                MODE_SHL: begin
                    stage_d  = {stage_q[W-LANE_W-1:0], sin_l};
                    shift_en = 1'b1;
                end
                MODE_LOAD: begin
                    stage_d = pin;
                    cnt_d   = '0;
                end
                default: begin
                    stage_d = stage_q;
                end
            endcase
        end
        // Counter saturates at DEPTH and never wraps.
        if (shift_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pout      = stage_q;
    assign sout_r    = stage_q[LANE_W-1:0];
    assign sout_l    = stage_q[W-1 -: LANE_W];
    assign shift_cnt = cnt_q;
    assign full      = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed + randomized checks of univ_shift_reg
// in a 4x1 and an 8x4 configuration against an array-based model.
module tb_univ_shift_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: DEPTH=4, LANE_W=1
    logic        a_reset, a_en;
    logic [1:0]  a_mode;
    logic [0:0]  a_sin_r, a_sin_l;
    logic [3:0]  a_pin, a_pout;
    logic [0:0]  a_sout_r, a_sout_l;
    logic [2:0]  a_cnt;
    logic        a_full;

    // DUT B: DEPTH=8, LANE_W=4
    logic        b_reset, b_en;
    logic [1:0]  b_mode;
    logic [3:0]  b_sin_r, b_sin_l;
    logic [31:0] b_pin, b_pout;
    logic [3:0]  b_sout_r, b_sout_l;
    logic [3:0]  b_cnt;
    logic        b_full;

    univ_shift_reg #(.DEPTH(4), .LANE_W(1)) u_a (
        .clk(clk), .reset(a_reset), .en(a_en), .mode(a_mode),
        .sin_r(a_sin_r), .sin_l(a_sin_l), .pin(a_pin), .pout(a_pout),
        .sout_r(a_sout_r), .sout_l(a_sout_l), .shift_cnt(a_cnt),
        .full(a_full)
    );

    univ_shift_reg #(.DEPTH(8), .LANE_W(4)) u_b (
        .clk(clk), .reset(b_reset), .en(b_en), .mode(b_mode),
        .sin_r(b_sin_r), .sin_l(b_sin_l), .pin(b_pin), .pout(b_pout),
        .sout_r(b_sout_r), .sout_l(b_sout_l), .shift_cnt(b_cnt),
        .full(b_full)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one array of lane values per DUT, plus a count.
    logic [3:0] ms [2][8];
    int         mc [2];

    bit seq [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit exp2 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mstep(input int k, input int d, input int w,
                         input logic rst, input logic en,
                         input logic [1:0] mode,
                         input logic [3:0] sr, input logic [3:0] sl,
                         input logic [31:0] pin);
        logic [3:0] old [8];
        logic [3:0] mask;
        mask = 4'((1 << w) - 1);
        for (int i = 0; i < 8; i++) old[i] = ms[k][i];
        if (rst) begin
            for (int i = 0; i < 8; i++) ms[k][i] = '0;
            mc[k] = 0;
        end else if (en) begin
            case (mode)
                2'b01: begin
                    for (int i = 0; i < d - 1; i++) ms[k][i] = old[i+1];
                    ms[k][d-1] = sr & mask;
                    mc[k] = (mc[k] + 1 > d) ? d : mc[k] + 1;
                end
                2'b10: begin
                    for (int i = 1; i < d; i++) ms[k][i] = old[i-1];
                    ms[k][0] = sl & mask;
                    mc[k] = (mc[k] + 1 > d) ? d : mc[k] + 1;
                end
                2'b11: begin
                    for (int i = 0; i < d; i++)
                        ms[k][i] = 4'(pin >> (i * w)) & mask;
                    mc[k] = 0;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] pack(input int k, input int d,
                                         input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < d; i++) r = r | (32'(ms[k][i]) << (i * w));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        mstep(0, 4, 1, a_reset, a_en, a_mode, a_sin_r, a_sin_l,
              {28'b0, a_pin});
        mstep(1, 8, 4, b_reset, b_en, b_mode, b_sin_r, b_sin_l, b_pin);
        #1;
        chk("a_pout",   a_pout,   pack(0, 4, 1));
        chk("a_sout_r", a_sout_r, ms[0][0]);
        chk("a_sout_l", a_sout_l, ms[0][3]);
        chk("a_cnt",    a_cnt,    mc[0]);
        chk("a_full",   a_full,   mc[0] == 4);
        chk("b_pout",   b_pout,   pack(1, 8, 4));
        chk("b_sout_r", b_sout_r, ms[1][0]);
        chk("b_sout_l", b_sout_l, ms[1][7]);
        chk("b_cnt",    b_cnt,    mc[1]);
        chk("b_full",   b_full,   mc[1] == 8);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mc[k] = 0;
            for (int i = 0; i < 8; i++) ms[k][i] = '0;
        end
        a_reset = 1; a_en = 0; a_mode = 0; a_sin_r = 0; a_sin_l = 0;
        a_pin = 0;
        b_reset = 1; b_en = 0; b_mode = 0; b_sin_r = 0; b_sin_l = 0;
        b_pin = 0;
        tick();
        tick();
        chk("rst_a_pout", a_pout, 0);
        chk("rst_a_cnt",  a_cnt,  0);
        chk("rst_a_full", a_full, 0);
        chk("rst_b_pout", b_pout, 0);
        a_reset = 0;
        b_reset = 0;

        // Serial-in on sin_r, saturation on the 5th shift
        a_en = 1; a_mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            a_sin_r = seq[i];
            tick();
        end
        chk("t1_pout",   a_pout,   4'b1101);
        chk("t1_sout_r", a_sout_r, 1);
        chk("t1_full",   a_full,   1);
        chk("t1_cnt",    a_cnt,    4);
        a_sin_r = 0;
        tick();
        chk("t1_sat", a_cnt, 4);

        // Load then shift left out of sout_l
        a_mode = 2'b11; a_pin = 4'b1001;
        tick();
        chk("t2_cnt0", a_cnt, 0);
        chk("t2_sl0",  a_sout_l, 1);
        a_mode = 2'b10; a_sin_l = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_sout_l", a_sout_l, exp2[i]);
            chk("t2_cnt",    a_cnt,    i + 1);
        end
        chk("t2_pout", a_pout, 0);

        // 8x4 load and drain through sout_r
        b_en = 1; b_mode = 2'b11; b_pin = 32'h76543210;
        tick();
        chk("t3_sout_r0", b_sout_r, 0);
        b_mode = 2'b01; b_sin_r = 4'hF;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t3_sout_r", b_sout_r, (i < 8) ? i : 15);
        end
        chk("t3_pout", b_pout, 32'hFFFFFFFF);
        chk("t3_full", b_full, 1);
        b_en = 0;

        // Enable gaps mid-sequence
        a_reset = 1;
        tick();
        a_reset = 0; a_mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                a_en = 0;
                for (int j = 0; j < 3; j++) begin
                    a_sin_r = ~a_sin_r;
                    tick();
                    chk("t4_hold_cnt", a_cnt, 2);
                end
                a_en = 1;
            end
            a_sin_r = seq[i];
            tick();
        end
        chk("t4_pout", a_pout, 4'b1101);
        chk("t4_cnt",  a_cnt,  4);

        // Reset beats a simultaneous load
        a_reset = 1;
        tick();
        a_reset = 0; a_mode = 2'b01; a_sin_r = 1;
        tick();
        tick();
        a_reset = 1; a_mode = 2'b11; a_pin = 4'hF;
        tick();
        chk("t5_pout", a_pout, 0);
        chk("t5_cnt",  a_cnt,  0);
        chk("t5_full", a_full, 0);
        a_reset = 0; a_mode = 2'b01; a_sin_r = 1;
        tick();
        chk("t5_resume", a_pout, 4'b1000);

        // Alternating directions from a load of 0110
        a_mode = 2'b11; a_pin = 4'b0110;
        tick();
        for (int i = 0; i < 6; i++) begin
            a_mode  = (i % 2 == 0) ? 2'b01 : 2'b10;
            a_sin_r = 1'($urandom);
            a_sin_l = 1'($urandom);
            tick();
        end
        chk("t6_cnt", a_cnt, 4);

        // Randomized traffic on both instances
        for (int n = 0; n < 400; n++) begin
            a_reset = ($urandom_range(0, 31) == 0);
            a_en    = ($urandom_range(0, 3) != 0);
            a_mode  = 2'($urandom);
            a_sin_r = 1'($urandom);
            a_sin_l = 1'($urandom);
            a_pin   = 4'($urandom);
            b_reset = ($urandom_range(0, 31) == 0);
            b_en    = ($urandom_range(0, 3) != 0);
            b_mode  = 2'($urandom);
            b_sin_r = 4'($urandom);
            b_sin_l = 4'($urandom);
            b_pin   = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
